// File: rtl/sw_collect_pkg.sv
// Shared types and limits for the SmithWaterman top-K result collector.
// CALC_BIT / T_IDX_BIT mirror the core's `CALC_BIT and `MAX_T_NUM_BIT.
package sw_collect_pkg;
  localparam int CALC_BIT  = 16;
  localparam int T_IDX_BIT = 8;
  localparam int TOPK_MIN  = 1;
  localparam int TOPK_MAX  = 8;

  typedef struct packed {
    logic [CALC_BIT-1:0]  score;
    logic [T_IDX_BIT-1:0] t_idx;
  } entry_t;

  // Rank is carried on 3 bits, so the list depth is forced into 1..8.
  function automatic int clamp_topk(input int k);
    if (k < TOPK_MIN) return TOPK_MIN;
    if (k > TOPK_MAX) return TOPK_MAX;
    return k;
  endfunction
endpackage

// File: rtl/sw_topk_insert.sv
// Combinational sorted insert of one entry into a descending list of K entries.
// Ties keep the existing (earlier) entry above the new one.
module sw_topk_insert
  import sw_collect_pkg::*;
#(
  parameter int K = 4
) (
  input  entry_t [K-1:0] list_in,
  input  logic   [3:0]   cnt_in,
  input  entry_t         ent_in,
  output entry_t [K-1:0] list_out,
  output logic   [3:0]   n_out
);

  logic [3:0] pos;

  always_comb begin
    pos = 4'd0;
    for (int i = 0; i < K; i++) begin
      if ((4'(i) < cnt_in) && (list_in[i].score >= ent_in.score)) pos = pos + 4'd1;
    end
  end

  // Entries below the insertion point shift down one rank; the last one falls off.
  always_comb begin
    list_out = list_in;
    for (int i = 0; i < K; i++) begin
      if (4'(i) < pos) list_out[i] = list_in[i];
      else if (4'(i) == pos) list_out[i] = ent_in;
      else list_out[i] = list_in[(i == 0) ? 0 : i - 1];
    end
  end

  assign n_out = (cnt_in == 4'(K)) ? cnt_in : cnt_in + 4'd1;

endmodule

// File: rtl/sw_topk_collector.sv
// Keeps a sorted top-K list per query from the SmithWaterman result stream and
// drains a snapshot of it per query over a valid/ready port without stalling the core.
module sw_topk_collector
  import sw_collect_pkg::*;
#(
  parameter int Q_IDX_BIT = 8,
  parameter int TOPK      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_valid_i,
  input  logic [CALC_BIT-1:0]  sw_result_i,
  input  logic                 sw_change_q_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [Q_IDX_BIT-1:0] out_q_idx_o,
  output logic [2:0]           out_rank_o,
  output logic [T_IDX_BIT-1:0] out_t_idx_o,
  output logic [CALC_BIT-1:0]  out_score_o,
  output logic                 out_last_o,
  output logic                 overflow_o
);

  localparam int K = clamp_topk(TOPK);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state;
  entry_t [K-1:0]       act_list, ins_list, bank;
  entry_t               new_ent, sel;
  logic [3:0]           act_cnt, ins_n, bank_n;
  logic [2:0]           rank;
  logic [T_IDX_BIT-1:0] t_cnt;
  logic [Q_IDX_BIT-1:0] q_cnt, bank_q;
  logic                 snap, xfer, last_xfer, can_load;

  assign new_ent = '{score: sw_result_i, t_idx: t_cnt};

  sw_topk_insert #(.K(K)) u_insert (
    .list_in  (act_list),
    .cnt_in   (act_cnt),
    .ent_in   (new_ent),
    .list_out (ins_list),
    .n_out    (ins_n)
  );

  assign snap      = sw_valid_i & sw_change_q_i;
  assign xfer      = out_valid_o & out_ready_i;
  assign last_xfer = xfer & out_last_o;
  // The bank may be reloaded on the very edge its last record leaves.
  assign can_load  = (state == IDLE) | last_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_list <= '0;
      act_cnt  <= 4'd0;
      t_cnt    <= '0;
      q_cnt    <= '0;
    end else if (sw_valid_i) begin
      if (sw_change_q_i) begin
        act_cnt <= 4'd0;
        t_cnt   <= '0;
        q_cnt   <= q_cnt + 1'b1;
      end else begin
        act_list <= ins_list;
        act_cnt  <= ins_n;
        t_cnt    <= (&t_cnt) ? t_cnt : t_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      rank        <= 3'd0;
      bank        <= '0;
      bank_n      <= 4'd0;
      bank_q      <= '0;
      overflow_o  <= 1'b0;
    end else if (snap && can_load) begin
      state       <= DRAIN;
      out_valid_o <= 1'b1;
      rank        <= 3'd0;
      bank        <= ins_list;
      bank_n      <= ins_n;
      bank_q      <= q_cnt;
    end else begin
      if (snap) overflow_o <= 1'b1;
      if (last_xfer) begin
        state       <= IDLE;
        out_valid_o <= 1'b0;
        rank        <= 3'd0;
      end else if (xfer) begin
        rank <= rank + 3'd1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < K; i++) begin
      if (rank == 3'(i)) sel = bank[i];
    end
  end

  assign out_q_idx_o = bank_q;
  assign out_rank_o  = rank;
  assign out_t_idx_o = sel.t_idx;
  assign out_score_o = sel.score;
  assign out_last_o  = out_valid_o && ({1'b0, rank} == bank_n - 4'd1);

endmodule

// File: tb/tb_sw_topk_collector.sv
// Directed and randomized bench for sw_topk_collector against a queue-based top-K model.
module tb_sw_topk_collector;
  import sw_collect_pkg::*;

  localparam int QB = 2;
  localparam int K  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sw_valid_i = 1'b0;
  logic [CALC_BIT-1:0]  sw_result_i = '0;
  logic                 sw_change_q_i = 1'b0;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b0;
  logic [QB-1:0]        out_q_idx_o;
  logic [2:0]           out_rank_o;
  logic [T_IDX_BIT-1:0] out_t_idx_o;
  logic [CALC_BIT-1:0]  out_score_o;
  logic                 out_last_o;
  logic                 overflow_o;

  sw_topk_collector #(.Q_IDX_BIT(QB), .TOPK(K)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_valid_i    (sw_valid_i),
    .sw_result_i   (sw_result_i),
    .sw_change_q_i (sw_change_q_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_q_idx_o   (out_q_idx_o),
    .out_rank_o    (out_rank_o),
    .out_t_idx_o   (out_t_idx_o),
    .out_score_o   (out_score_o),
    .out_last_o    (out_last_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int rank;
    int t;
    int s;
    bit last;
  } rec_t;

  int   compared = 0;
  int   mismatched = 0;
  rec_t seen[$];

  // Reference model: raw scores of the open query and the pending drain bank.
  int cur[$];
  int m_q;
  bit m_drain;
  bit m_ovf;
  int m_bank_s[8];
  int m_bank_t[8];
  int m_bank_n;
  int m_bank_q;
  int m_pos;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    cur.delete();
    m_q = 0;
    m_drain = 1'b0;
    m_ovf = 1'b0;
    m_bank_n = 0;
    m_bank_q = 0;
    m_pos = 0;
  endfunction

  // Best K of the query: highest score first, earliest target on ties.
  function automatic void model_load();
    bit taken[];
    int best;
    taken = new[cur.size()];
    m_bank_n = (cur.size() < K) ? cur.size() : K;
    for (int r = 0; r < m_bank_n; r++) begin
      best = -1;
      for (int i = 0; i < cur.size(); i++)
        if (!taken[i] && (best < 0 || cur[i] > cur[best])) best = i;
      taken[best] = 1'b1;
      m_bank_s[r] = cur[best];
      m_bank_t[r] = best;
    end
    m_bank_q = m_q;
    m_pos = 0;
    m_drain = 1'b1;
  endfunction

  function automatic void model_edge(input bit v, input bit c, input int s, input bit r);
    bit xfer;
    bit lastx;
    xfer  = m_drain && r;
    lastx = xfer && (m_pos == m_bank_n - 1);
    if (xfer) m_pos++;
    if (lastx) m_drain = 1'b0;
    if (v) begin
      cur.push_back(s);
      if (c) begin
        if (!m_drain) model_load();
        else m_ovf = 1'b1;
        cur.delete();
        m_q = (m_q + 1) % (1 << QB);
      end
    end
  endfunction

  task automatic check_output();
    check("valid", out_valid_o, m_drain);
    check("overflow", overflow_o, m_ovf);
    if (m_drain) begin
      check("q_idx", out_q_idx_o, m_bank_q);
      check("rank", out_rank_o, m_pos);
      check("t_idx", out_t_idx_o, m_bank_t[m_pos]);
      check("score", out_score_o, m_bank_s[m_pos]);
      check("last", out_last_o, m_pos == m_bank_n - 1);
    end
  endtask

  // One clock: check, drive, log any transfer, advance the model on the edge.
  task automatic apply_stimulus(input bit v, input bit c, input int s, input bit r);
    check_output();
    sw_valid_i    = v;
    sw_change_q_i = c;
    sw_result_i   = CALC_BIT'(s);
    out_ready_i   = r;
    if (out_valid_o && r)
      seen.push_back('{q: int'(out_q_idx_o), rank: int'(out_rank_o), t: int'(out_t_idx_o),
                       s: int'(out_score_o), last: out_last_o});
    @(posedge clk);
    model_edge(v, c, s, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    sw_valid_i = 1'b0;
    sw_change_q_i = 1'b0;
    out_ready_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_drain; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b1);
    check("drain_done", out_valid_o, 1'b0);
  endtask

  task automatic feed(input int scores[$], input bit r);
    for (int i = 0; i < scores.size(); i++)
      apply_stimulus(1'b1, i == scores.size() - 1, scores[i], r);
  endtask

  task automatic check_seen(input int i, input int q, input int rk, input int t, input int s, input bit last);
    if (i >= seen.size()) begin
      check("seen_count", seen.size(), i + 1);
    end else begin
      check("rec_q", seen[i].q, q);
      check("rec_rank", seen[i].rank, rk);
      check("rec_t", seen[i].t, t);
      check("rec_score", seen[i].s, s);
      check("rec_last", seen[i].last, last);
    end
  endtask

  initial begin
    int c1[$];
    int c2[$];
    int t1[4];
    int s1[4];
    bit v;
    bit c;
    c1 = '{5, 9, 3, 9, 7};
    c2 = '{4, 6};
    t1 = '{1, 3, 4, 0};
    s1 = '{9, 9, 7, 5};

    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_score", out_score_o, 0);
    check("rst_last", out_last_o, 1'b0);
    check("rst_overflow", overflow_o, 1'b0);

    // Case 1: ties rank the earlier target first.
    seen.delete();
    feed(c1, 1'b1);
    check("lat_valid", out_valid_o, 1'b1);
    drain();
    check("c1_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) check_seen(i, 0, i, t1[i], s1[i], i == 3);

    // Case 2: short query, n = 2.
    seen.delete();
    feed(c2, 1'b1);
    drain();
    check("c2_count", seen.size(), 2);
    check_seen(0, 1, 0, 1, 6, 1'b0);
    check_seen(1, 1, 1, 0, 4, 1'b1);

    // Case 3: backpressure holds the rank-0 payload.
    seen.delete();
    feed(c1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_t", out_t_idx_o, 1);
      check("hold_score", out_score_o, 9);
      apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    end
    drain();
    check("c3_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) check_seen(i, 2, i, t1[i], s1[i], i == 3);

    // Case 4: collision drops the second snapshot.
    do_reset();
    seen.delete();
    apply_stimulus(1'b1, 1'b1, 5, 1'b0);
    apply_stimulus(1'b1, 1'b1, 6, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    check("c4_overflow", overflow_o, 1'b1);
    drain();
    check("c4_count", seen.size(), 1);
    check_seen(0, 0, 0, 0, 5, 1'b1);
    apply_stimulus(1'b1, 1'b1, 8, 1'b1);
    drain();
    check_seen(1, 2, 0, 0, 8, 1'b1);

    // Case 5: reset in the middle of a drain.
    seen.delete();
    feed(c1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1);
    check("c5_pre_ranks", seen.size(), 2);
    rst = 1'b1;
    #1;
    check("c5_valid", out_valid_o, 1'b0);
    check("c5_overflow", overflow_o, 1'b0);
    @(negedge clk);
    do_reset();
    seen.delete();
    apply_stimulus(1'b1, 1'b1, 11, 1'b1);
    drain();
    check_seen(0, 0, 0, 0, 11, 1'b1);

    // Case 6: q_idx wraps on a 2-bit counter.
    do_reset();
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 20 + i, 1'b1);
      apply_stimulus(1'b0, 1'b0, 0, 1'b1);
    end
    check("c6_count", seen.size(), 5);
    for (int i = 0; i < 5; i++) check_seen(i, i % 4, 0, 0, 20 + i, 1'b1);

    // Random traffic with ties, collisions and backpressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = v && (($urandom_range(0, 5) == 0) || cur.size() >= 200);
      apply_stimulus(v, c, int'($urandom_range(0, 15)), $urandom_range(0, 9) < 6);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
